writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Writer-side companion to the core register bank. Merges ALU results and out-of-band load responses into the bank's single write port (`reg_write`/`rd_sel`/`write_data`). Buffers ALU results that lose arbitration in a small in-order FIFO. Tracks registers with outstanding loads in a scoreboard, and raises `stall` for any read whose value is not yet committed to the bank.

## Interface
Parameters:
- DEPTH, 2, ALU result FIFO entries; power of two, ≥2

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_valid  in  1  load response; no backpressure, always accepted
- ld_rd  in  5  load destination register
- ld_data  in  32  load data
- ld_issue  in  1  load issued this cycle; marks ld_issue_rd pending
- ld_issue_rd  in  5  destination of the issued load
- rs1_sel  in  5  decode-stage source 1
- rs2_sel  in  5  decode-stage source 2
- stall  out  1  a source value is not yet in the bank
- reg_write  out  1  bank write enable, registered
- rd_sel  out  5  bank write address, registered
- write_data  out  32  bank write data, registered
- fifo_count  out  clog2(DEPTH)+1  ALU FIFO occupancy

## Operation
- Reset (reset=0) does all of the following:
  - Empties the FIFO and clears all 32 busy bits.
  - Clears reg_write, rd_sel and write_data to 0.
  - Clears fifo_count to 0.
  - Forces alu_ready to 0.
- After reset, alu_ready = (fifo_count != DEPTH).
- Each cycle the output-register source is chosen by priority:
  1. ld_valid: write ld_rd/ld_data.
  2. FIFO non-empty: pop the head and write it.
  3. Accepted ALU result with FIFO empty: bypass, write alu_rd/alu_data directly.
  4. Otherwise reg_write=0 next cycle. rd_sel and write_data hold their values.
- ALU results are written in acceptance order. The FIFO is never bypassed while non-empty.
- An accepted ALU result that is not written this cycle is pushed.
- A push and a pop in the same cycle are both allowed; fifo_count stays unchanged.
- Register 0 handling:
  - ALU results with alu_rd=0 are accepted and discarded: no push, no write.
  - Load responses with ld_rd=0 are dropped.
  - reg_write is never asserted with rd_sel=0.
- Scoreboard:
  - ld_issue with ld_issue_rd≠0 sets busy[ld_issue_rd].
  - ld_valid clears busy[ld_rd].
  - If both target the same register in the same cycle, set wins.
- stall = 1 iff, for rs1_sel or rs2_sel (nonzero) at least one of these holds:
  - busy[rs] is set;
  - rs matches a valid FIFO entry's rd;
  - reg_write=1 and rs == rd_sel, i.e. the write is not yet in the bank.
- stall is combinational from current state and current rs*_sel only. It does not depend on same-cycle alu_valid or ld_valid.
- Reset asserted mid-operation discards FIFO contents and any in-flight output write immediately.

## Timing
- Latency for a load response or an ALU bypass: the result is accepted in cycle t, reg_write is high in t+1, and the bank commits at the end of t+1.
- Queued ALU result: written in the cycle after it reaches the FIFO head with no ld_valid present.
- Sustained ld_valid starves the FIFO. alu_ready falls in the cycle after the FIFO fills.
- The write port sustains one write per cycle. With ld_valid and alu_valid both high, throughput is one write per cycle and the FIFO grows.
- fifo_count and busy bits update on the same edge as the output register.

## Test plan
- Reset during active writes: assert reset=0 mid-stream -> reg_write=0, rd_sel=0, write_data=0, fifo_count=0, alu_ready=0, stall=0 immediately. After release alu_ready=1.
- ALU bypass: alu_valid, alu_rd=5, alu_data=0xDEADBEEF at cycle t -> in t+1: reg_write=1, rd_sel=5, write_data=0xDEADBEEF, stall=1 for rs1_sel=5. In t+2: stall=0.
- Collision and ordering: at cycle t, ld_valid (rd=3, 0x11) together with ALU results rd=4 (0x22) and rd=6 (0x33) in t and t+1 -> writes x3=0x11, x4=0x22, x6=0x33 on consecutive cycles. fifo_count peaks at 1.
- FIFO full: ld_valid held 4 cycles while alu_valid is held with DEPTH=2 -> exactly 2 ALU results accepted, alu_ready=0 from the third cycle. After ld_valid drops, the queued results drain in order and alu_ready returns to 1.
- Scoreboard: ld_issue rd=7 -> stall=1 for rs2_sel=7 until ld_valid rd=7. Same-cycle ld_issue rd=7 and ld_valid rd=7 -> busy[7] stays set.
- x0 handling: alu_rd=0 and ld_rd=0 -> alu_ready handshake completes, reg_write stays 0. ld_issue rd=0 -> no stall for rs1_sel=0.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Merges load responses and ALU results onto the register bank's single write port.
// Also tracks registers with pending loads and raises stall for reads whose value is not yet in the bank.
module writeback_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    input  logic                     ld_valid,
    input  logic [4:0]               ld_rd,
    input  logic [31:0]              ld_data,
    input  logic                     ld_issue,
    input  logic [4:0]               ld_issue_rd,
    input  logic [4:0]               rs1_sel,
    input  logic [4:0]               rs2_sel,
    output logic                     stall,
    output logic                     reg_write,
    output logic [4:0]               rd_sel,
    output logic [31:0]              write_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t              fifo_q [DEPTH];
    logic [AW-1:0]    head, tail;
    logic [31:0]      busy, busy_d;
    logic [DEPTH-1:0] ent_vld;
    logic [1:0][4:0]  rs_sel;

    logic ld_wr, fifo_empty, alu_keep;
    logic do_pop, do_push, do_bypass;
    logic wr_en_d;
    wb_t  wr_d;

    assign alu_ready  = reset && (fifo_count != CW'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign ld_wr      = ld_valid && (ld_rd != 5'd0);
    // x0 results still complete the handshake but never reach the FIFO or the bank
    assign alu_keep   = alu_valid && alu_ready && (alu_rd != 5'd0);

    assign do_pop    = !ld_wr && !fifo_empty;
    assign do_bypass = !ld_wr && fifo_empty && alu_keep;
    assign do_push   = alu_keep && !do_bypass;

    always_comb begin
        wr_en_d = 1'b0;
        wr_d    = '{rd: rd_sel, data: write_data};
        if (ld_wr) begin
            wr_en_d = 1'b1;
            wr_d    = '{rd: ld_rd, data: ld_data};
        end else if (do_pop) begin
            wr_en_d = 1'b1;
            wr_d    = fifo_q[head];
        end else if (do_bypass) begin
            wr_en_d = 1'b1;
            wr_d    = '{rd: alu_rd, data: alu_data};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reg_write  <= 1'b0;
            rd_sel     <= 5'd0;
            write_data <= 32'd0;
        end else begin
            reg_write  <= wr_en_d;
            rd_sel     <= wr_d.rd;
            write_data <= wr_d.data;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) fifo_q[tail] <= '{rd: alu_rd, data: alu_data};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push) tail <= tail + AW'(1);
            if (do_pop)  head <= head + AW'(1);
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Issue is applied after the clear so a same-cycle issue/response keeps the bit set
    always_comb begin
        busy_d = busy;
        if (ld_valid) busy_d[ld_rd] = 1'b0;
        if (ld_issue && (ld_issue_rd != 5'd0)) busy_d[ld_issue_rd] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) busy <= '0;
        else        busy <= busy_d;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ent_vld[i] = ({1'b0, AW'(AW'(i) - head)} < fifo_count);
    end

    assign rs_sel = {rs2_sel, rs1_sel};

    always_comb begin
        stall = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (rs_sel[s] != 5'd0) begin
                if (busy[rs_sel[s]] || (reg_write && (rd_sel == rs_sel[s]))) stall = 1'b1;
                for (int i = 0; i < DEPTH; i++)
                    if (ent_vld[i] && (fifo_q[i].rd == rs_sel[s])) stall = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table, hand sequences for reset/full FIFO,
// then random traffic against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic [4:0]  rs1_sel, rs2_sel;
    logic        stall, reg_write;
    logic [4:0]  rd_sel;
    logic [31:0] write_data;
    logic [$clog2(DEPTH):0] fifo_count;

    writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .stall(stall),
        .reg_write(reg_write), .rd_sel(rd_sel), .write_data(write_data),
        .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        av; logic [4:0] ard; logic [31:0] ad;
        logic        lv; logic [4:0] lrd; logic [31:0] ld;
        logic        iv; logic [4:0] ird;
        logic [4:0]  r1, r2;
        logic        e_rw; logic [4:0] e_rd; logic [31:0] e_wd;
        int          e_cnt; logic e_rdy; logic e_st;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Reference model: FIFO as a queue, scoreboard as a bit array
    ent_t        mq[$];
    bit          busy_m[32];
    bit          m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;

    task automatic model_reset();
        mq.delete();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        m_rw = 1'b0; m_rd = '0; m_wd = '0;
    endtask

    function automatic bit m_stall(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        if (busy_m[rs]) return 1'b1;
        if (m_rw && m_rd == rs) return 1'b1;
        foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        bit   acc, used;
        ent_t e;
        acc  = alu_valid && (mq.size() != DEPTH);
        used = 1'b0;
        m_rw = 1'b0;
        if (ld_valid && ld_rd != 5'd0) begin
            m_rw = 1'b1; m_rd = ld_rd; m_wd = ld_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_rw = 1'b1; m_rd = e.rd; m_wd = e.data;
        end else if (acc && alu_rd != 5'd0) begin
            m_rw = 1'b1; m_rd = alu_rd; m_wd = alu_data; used = 1'b1;
        end
        if (acc && alu_rd != 5'd0 && !used) begin
            e.rd = alu_rd; e.data = alu_data;
            mq.push_back(e);
        end
        if (ld_valid) busy_m[ld_rd] = 1'b0;
        if (ld_issue && ld_issue_rd != 5'd0) busy_m[ld_issue_rd] = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic rw, input logic [4:0] rd,
                             input logic [31:0] wd, input int cnt, input logic rdy, input logic st);
        chk({tag, ".reg_write"},  32'(reg_write),  32'(rw));
        chk({tag, ".rd_sel"},     32'(rd_sel),     32'(rd));
        chk({tag, ".write_data"}, write_data,      wd);
        chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(cnt));
        chk({tag, ".alu_ready"},  32'(alu_ready),  32'(rdy));
        chk({tag, ".stall"},      32'(stall),      32'(st));
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        ld_valid = 0; ld_rd = '0; ld_data = '0;
        ld_issue = 0; ld_issue_rd = '0;
        rs1_sel = '0; rs2_sel = '0;
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                input logic iv, input logic [4:0] ird,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic e_rw, input logic [4:0] e_rd, input logic [31:0] e_wd,
                                input int e_cnt, input logic e_rdy, input logic e_st);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
        v.e_rw = e_rw; v.e_rd = e_rd; v.e_wd = e_wd; v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_st = e_st;
        return v;
    endfunction

    vec_t vt[17];

    initial begin
        int acc;
        // Expected outputs are those visible before the edge of each row
        vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0, 0, 0,  0, 0, 32'h0,        0, 1, 0);
        vt[1]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 5, 0,  1, 5, 32'hDEADBEEF, 0, 1, 1);
        vt[2]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 5, 0,  0, 5, 32'hDEADBEEF, 0, 1, 0);
        vt[3]  = mk(1, 4, 32'h22,       1, 3, 32'h11,0, 0, 0, 0,  0, 5, 32'hDEADBEEF, 0, 1, 0);
        vt[4]  = mk(1, 6, 32'h33,       0, 0, 0,     0, 0, 4, 0,  1, 3, 32'h11,       1, 1, 1);
        vt[5]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 6, 0,  1, 4, 32'h22,       1, 1, 1);
        vt[6]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 6, 0,  1, 6, 32'h33,       0, 1, 1);
        vt[7]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 6, 0,  0, 6, 32'h33,       0, 1, 0);
        vt[8]  = mk(1, 0, 32'h55,       1, 0, 32'h66,1, 0, 0, 0,  0, 6, 32'h33,       0, 1, 0);
        vt[9]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 0,  0, 6, 32'h33,       0, 1, 0);
        vt[10] = mk(0, 0, 0,            0, 0, 0,     1, 7, 0, 7,  0, 6, 32'h33,       0, 1, 0);
        vt[11] = mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 7,  0, 6, 32'h33,       0, 1, 1);
        vt[12] = mk(0, 0, 0,            1, 7, 32'h77,1, 7, 0, 7,  0, 6, 32'h33,       0, 1, 1);
        vt[13] = mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 7,  1, 7, 32'h77,       0, 1, 1);
        vt[14] = mk(0, 0, 0,            1, 7, 32'h78,0, 0, 0, 7,  0, 7, 32'h77,       0, 1, 1);
        vt[15] = mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 7,  1, 7, 32'h78,       0, 1, 1);
        vt[16] = mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 7,  0, 7, 32'h78,       0, 1, 0);

        reset = 1'b0;
        idle();
        model_reset();
        @(negedge clock); @(negedge clock);
        #1 check_out("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;

        foreach (vt[i]) begin
            alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].ad;
            ld_valid = vt[i].lv; ld_rd = vt[i].lrd; ld_data = vt[i].ld;
            ld_issue = vt[i].iv; ld_issue_rd = vt[i].ird;
            rs1_sel = vt[i].r1; rs2_sel = vt[i].r2;
            #1 check_out($sformatf("vec%0d", i), vt[i].e_rw, vt[i].e_rd, vt[i].e_wd,
                         vt[i].e_cnt, vt[i].e_rdy, vt[i].e_st);
            model_step();
            @(negedge clock);
        end

        // Loads hog the port for 4 cycles while ALU results keep arriving
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            idle();
            ld_valid = 1; ld_rd = 5'(8 + c); ld_data = 32'h100 + 32'(c);
            alu_valid = 1;
            alu_rd = (c == 0) ? 5'd12 : (c == 1) ? 5'd13 : 5'd14;
            alu_data = 32'h200 + 32'(alu_rd - 5'd12);
            #1;
            chk($sformatf("full%0d.alu_ready", c), 32'(alu_ready), (c < 2) ? 32'd1 : 32'd0);
            chk($sformatf("full%0d.fifo_count", c), 32'(fifo_count), (c == 0) ? 32'd0 : (c == 1) ? 32'd1 : 32'd2);
            if (c > 0) chk($sformatf("full%0d.rd_sel", c), 32'(rd_sel), 32'(7 + c));
            if (alu_valid && alu_ready) acc++;
            model_step();
            @(negedge clock);
        end
        chk("full.accepted", 32'(acc), 32'd2);
        idle();
        #1 check_out("drain0", 1, 11, 32'h103, 2, 0, 0); model_step(); @(negedge clock);
        #1 check_out("drain1", 1, 12, 32'h200, 1, 1, 0); model_step(); @(negedge clock);
        #1 check_out("drain2", 1, 13, 32'h201, 0, 1, 0); model_step(); @(negedge clock);
        #1 check_out("drain3", 0, 13, 32'h201, 0, 1, 0); model_step(); @(negedge clock);

        // Reset in the middle of traffic
        ld_valid = 1; ld_rd = 10; ld_data = 32'hA;
        alu_valid = 1; alu_rd = 11; alu_data = 32'hB;
        ld_issue = 1; ld_issue_rd = 9;
        #1 model_step();
        @(negedge clock);
        idle();
        rs1_sel = 9;
        #1 check_out("pre_rst", 1, 10, 32'hA, 1, 1, 1);
        reset = 1'b0;
        #1 check_out("mid_rst", 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clock);
        #1 check_out("hold_rst", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1 check_out("post_rst", 0, 0, 0, 0, 1, 0);
        @(negedge clock);

        // Random traffic on a small register range to provoke collisions
        for (int n = 0; n < 400; n++) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
            ld_valid = ($urandom_range(0, 99) < 40);
            ld_rd = 5'($urandom_range(0, 7)); ld_data = $urandom;
            ld_issue = ($urandom_range(0, 99) < 30);
            ld_issue_rd = 5'($urandom_range(0, 7));
            rs1_sel = 5'($urandom_range(0, 7)); rs2_sel = 5'($urandom_range(0, 7));
            #1;
            check_out($sformatf("rnd%0d", n), m_rw, m_rd, m_wd, mq.size(),
                      (mq.size() != DEPTH), m_stall(rs1_sel) || m_stall(rs2_sel));
            model_step();
            @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
